// File: rtl/montgomery_param.sv
// Radix-2 bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// Define MONT_ABORT_EN to add an abort input that cancels a running product.
module montgomery_param #(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
`ifdef MONT_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             error
);

    localparam int SW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOP,
        FINAL
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [SW-1:0]    s_q;
    logic [CW-1:0]    cnt;

    logic [SW-1:0]    t_add;
    logic [SW-1:0]    t_red;
    logic [SW-1:0]    s_fin;
    logic             halt;

`ifdef MONT_ABORT_EN
    assign halt = abort;
`else
    assign halt = 1'b0;
`endif

    // a_q is shifted right each iteration, so bit 0 is always the current multiplier bit
    always_comb begin
        t_add = s_q;
        if (a_q[0]) begin
            t_add = s_q + {2'b00, b_q};
        end
        t_red = t_add;
        if (t_add[0]) begin
            t_red = t_add + {2'b00, m_q};
        end
        s_fin = s_q;
        if (s_q >= {2'b00, m_q}) begin
            s_fin = s_q - {2'b00, m_q};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            s_q    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            error  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (in_m[0]) begin
                            a_q   <= in_a;
                            b_q   <= in_b;
                            m_q   <= in_m;
                            s_q   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= LOOP;
                        end else begin
                            result <= '0;
                            done   <= 1'b1;
                            error  <= 1'b1;
                        end
                    end
                end
                LOOP: begin
                    if (halt) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        s_q <= t_red >> 1;
                        a_q <= a_q >> 1;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    if (halt) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        // s_q < 2m, so one conditional subtract fully reduces it
                        result <= WIDTH'(s_fin);
                        done   <= 1'b1;
                        error  <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
